uart_rx_param: RTL and testbench



---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_rx_param.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_param.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the parametrised UART blocks.
// The receiver's optional parity stage is controlled by the UART_PARITY_EN macro.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } uart_rx_state_t;

    // Clock cycles per oversampling tick (integer floor)
    function automatic int uart_div(input longint clk_hz, input longint baud, input longint os);
        return int'(clk_hz / (baud * os));
    endfunction

    // Counter width for a counter that holds 0..n-1, never narrower than one bit
    function automatic int uart_cw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle pulse every DIV clocks, phase
// restartable through iClr so sampling can be aligned to a start edge.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic iClk,
    input  logic iRst_n,
    input  logic iClr,
    output logic oTick
);

    localparam int CW = uart_cw(DIV);

    logic [CW-1:0] cnt;

    always_ff @(posedge iClk) begin
        if (!iRst_n || iClr) begin
            cnt <= '0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign oTick = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with mid-bit sampling and false-start rejection.
// Define UART_PARITY_EN to add a parity bit between data and stop.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic                 iRx,
    input  logic                 iParityOdd,
    output logic [DATA_BITS-1:0] oData,
    output logic                 oValid,
    output logic                 oFrameErr,
    output logic                 oParityErr,
    output logic                 oBusy
);

    localparam int DIV = uart_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int SW  = uart_cw(OVERSAMPLE);
    localparam int BW  = uart_cw(DATA_BITS);

    if (DIV < 1) begin : g_div_chk
        $error("uart_rx_param: CLK_HZ/(BAUD*OVERSAMPLE) must be at least 1");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_chk
        $error("uart_rx_param: DATA_BITS must be within 5..9");
    end
    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_os_chk
        $error("uart_rx_param: OVERSAMPLE must be even and at least 4");
    end

    logic                 rx_meta;
    logic                 rx_s;
    uart_rx_state_t       state;
    logic [SW-1:0]        scnt;
    logic [BW-1:0]        bidx;
    logic [DATA_BITS-1:0] shift;
    logic                 tick;
    logic                 clr;
    logic                 mid_tick;
    logic                 end_tick;

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= iRx;
            rx_s    <= rx_meta;
        end
    end

    // Restart the tick phase on the start edge so samples land mid-bit
    assign clr = (state == IDLE) && !rx_s;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iClr   (clr),
        .oTick  (tick)
    );

    assign mid_tick = tick && (scnt == SW'(OVERSAMPLE / 2 - 1));
    assign end_tick = tick && (scnt == SW'(OVERSAMPLE - 1));
    assign oBusy    = (state != IDLE);

`ifdef UART_PARITY_EN
    logic perr;
    localparam uart_rx_state_t AFTER_DATA = PARITY;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = iParityOdd;
    localparam uart_rx_state_t AFTER_DATA = STOP;
`endif

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state      <= IDLE;
            scnt       <= '0;
            bidx       <= '0;
            shift      <= '0;
            oData      <= '0;
            oValid     <= 1'b0;
            oFrameErr  <= 1'b0;
            oParityErr <= 1'b0;
`ifdef UART_PARITY_EN
            perr       <= 1'b0;
`endif
        end else begin
            oValid     <= 1'b0;
            oFrameErr  <= 1'b0;
            oParityErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        scnt  <= '0;
                    end
                end
                START: begin
                    if (mid_tick) begin
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            state <= DATA;
                            scnt  <= '0;
                            bidx  <= '0;
                        end
                    end else if (tick) begin
                        scnt <= scnt + 1'b1;
                    end
                end
                DATA: begin
                    if (end_tick) begin
                        shift <= {rx_s, shift[DATA_BITS-1:1]};
                        scnt  <= '0;
                        if (bidx == BW'(DATA_BITS - 1)) begin
                            state <= AFTER_DATA;
                        end else begin
                            bidx <= bidx + 1'b1;
                        end
                    end else if (tick) begin
                        scnt <= scnt + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (end_tick) begin
                        perr  <= ((^shift) ^ rx_s) != iParityOdd;
                        state <= STOP;
                        scnt  <= '0;
                    end else if (tick) begin
                        scnt <= scnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (end_tick) begin
                        oValid    <= 1'b1;
                        oData     <= shift;
                        oFrameErr <= !rx_s;
`ifdef UART_PARITY_EN
                        oParityErr <= perr;
`endif
                        scnt      <= '0;
                        // A low stop bit may be a break; wait for idle before rearming
                        state     <= rx_s ? IDLE : WAIT_HIGH;
                    end else if (tick) begin
                        scnt <= scnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: directed scenarios plus random frames
// checked against a frame-level reference model (builds with or without UART_PARITY_EN).
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam int CLK_HZ     = 1_600_000;
    localparam int BAUD       = 10_000;
    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int BIT        = CLK_HZ / BAUD;
`ifdef UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    // Stop midpoint after the start edge, plus 2 sync flops and the IDLE->START cycle
    localparam int LAT_EXP = (1 + DATA_BITS + PB) * BIT + BIT / 2 + 3;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } frm_t;

    logic       iClk = 1'b0;
    logic       iRst_n = 1'b0;
    logic       iRx = 1'b1;
    logic       iParityOdd = 1'b0;
    logic [7:0] oData;
    logic       oValid;
    logic       oFrameErr;
    logic       oParityErr;
    logic       oBusy;

    int     checks = 0;
    int     errors = 0;
    int     stray = 0;
    longint cyc = 0;
    frm_t   exp_q[$];
    frm_t   got_q[$];
    longint got_t[$];

    uart_rx_param #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .DATA_BITS  (DATA_BITS),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .iClk       (iClk),
        .iRst_n     (iRst_n),
        .iRx        (iRx),
        .iParityOdd (iParityOdd),
        .oData      (oData),
        .oValid     (oValid),
        .oFrameErr  (oFrameErr),
        .oParityErr (oParityErr),
        .oBusy      (oBusy)
    );

    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    always @(negedge iClk) begin
        if (oValid === 1'b1) begin
            got_q.push_back('{oData, oFrameErr, oParityErr});
            got_t.push_back(cyc);
        end else if (oFrameErr !== 1'b0 || oParityErr !== 1'b0) begin
            stray++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
            $error("%s observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic line(input logic b, input int n);
        iRx = b;
        repeat (n) @(negedge iClk);
    endtask

    // Drive one frame LSB first and record what a correct receiver must report
    task automatic send(input logic [7:0] d, input logic pbit, input logic stop);
        frm_t e;
        line(1'b0, BIT);
        for (int i = 0; i < DATA_BITS; i++) line(d[i], BIT);
`ifdef UART_PARITY_EN
        line(pbit, BIT);
        e.pe = (($countones(d) + int'(pbit)) % 2) != int'(iParityOdd);
`else
        e.pe = 1'b0;
`endif
        line(stop, BIT);
        e.d  = d;
        e.fe = !stop;
        exp_q.push_back(e);
    endtask

    function automatic logic good_par(input logic [7:0] d, input logic odd);
        return (($countones(d) % 2) == 1) ^ odd;
    endfunction

    task automatic drain(input string tag);
        frm_t e;
        frm_t g;
        check($sformatf("%s_count", tag), got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check($sformatf("%s_data", tag), g.d, e.d);
            check($sformatf("%s_ferr", tag), g.fe, e.fe);
            check($sformatf("%s_perr", tag), g.pe, e.pe);
        end
        exp_q.delete();
        got_q.delete();
        got_t.delete();
    endtask

    initial begin
        longint t0;
        logic [7:0] d;
        logic pb;
        logic st;
        int gap;

        // Reset state
        repeat (3) @(negedge iClk);
        check("rst_valid", oValid, 1'b0);
        check("rst_data", oData, 8'h00);
        check("rst_ferr", oFrameErr, 1'b0);
        check("rst_perr", oParityErr, 1'b0);
        check("rst_busy", oBusy, 1'b0);
        iRst_n = 1'b1;
        line(1'b1, 50);

        // Single frame and its latency from the start edge
        t0 = cyc;
        send(8'hA5, good_par(8'hA5, iParityOdd), 1'b1);
        line(1'b1, 100);
        check("single_count_raw", got_t.size(), 1);
        if (got_t.size() > 0) begin
            check("single_latency", (got_t[0] - t0 >= LAT_EXP - 8) && (got_t[0] - t0 <= LAT_EXP + 8), 1'b1);
        end
        drain("single");

        // False start: short low glitch must be rejected
        t0 = cyc;
        line(1'b0, 50);
        check("glitch_busy", oBusy, 1'b1);
        iRx = 1'b1;
        while (oBusy === 1'b1 && cyc - t0 < 300) @(negedge iClk);
        check("glitch_idle_within_83", (cyc - t0) <= 83, 1'b1);
        line(1'b1, 300);
        drain("glitch");

        // Framing error followed by a long break
        send(8'h3C, good_par(8'h3C, iParityOdd), 1'b0);
        line(1'b0, 2000);
        line(1'b1, 400);
        drain("break");
        send(8'h96, good_par(8'h96, iParityOdd), 1'b1);
        line(1'b1, 200);
        drain("after_break");

        // Back-to-back frames with no idle gap
        send(8'h00, good_par(8'h00, iParityOdd), 1'b1);
        send(8'hFF, good_par(8'hFF, iParityOdd), 1'b1);
        send(8'h55, good_par(8'h55, iParityOdd), 1'b1);
        line(1'b1, 200);
        drain("b2b");

`ifdef UART_PARITY_EN
        iParityOdd = 1'b0;
        send(8'h07, 1'b1, 1'b1);
        send(8'h07, 1'b0, 1'b1);
        line(1'b1, 200);
        drain("parity");
`endif

        // Random frames with random gaps, parity sense and stop corruption
        for (int k = 0; k < 6; k++) begin
            d  = 8'($urandom_range(0, 255));
            iParityOdd = 1'($urandom_range(0, 1));
            pb = good_par(d, iParityOdd) ^ ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 4) != 0);
            gap = $urandom_range(0, 300);
            if (!st && gap < 20) gap = 20;
            send(d, pb, st);
            line(1'b1, gap);
        end
        line(1'b1, 200);
        drain("random");

        // Reset in the middle of a frame discards it
        send(8'h5A, good_par(8'h5A, iParityOdd), 1'b1);
        line(1'b1, 100);
        drain("pre_reset");
        line(1'b0, BIT);
        line(1'b1, BIT);
        line(1'b0, BIT / 2);
        iRst_n = 1'b0;
        iRx    = 1'b1;
        @(negedge iClk);
        check("midrst_valid", oValid, 1'b0);
        check("midrst_data", oData, 8'h00);
        check("midrst_ferr", oFrameErr, 1'b0);
        check("midrst_perr", oParityErr, 1'b0);
        check("midrst_busy", oBusy, 1'b0);
        iRst_n = 1'b1;
        line(1'b1, 2000);
        drain("midrst");
        send(8'h81, good_par(8'h81, iParityOdd), 1'b1);
        line(1'b1, 200);
        drain("post_reset");

        check("stray_flags", stray, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
